// File: rtl/btn_conditioner_pkg.sv
// Shared definitions for the push-button conditioner: repeat-phase encoding,
// default timing constants and counter sizing helpers.
package btn_conditioner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rep_state_e;

    localparam int DEF_N_BTN        = 3;
    localparam int DEF_DEBOUNCE_CYC = 20000;
    localparam int DEF_REPEAT_DELAY = 10000000;
    localparam int DEF_REPEAT_RATE  = 2500000;

    // Width able to hold every value from 0 up to and including limit.
    function automatic int cnt_width(input int limit);
        return $clog2(limit + 1);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_conditioner_channel.sv
// One button channel: two-flop synchronizer, debounce counter and the
// auto-repeat phase machine driving registered level/press/release outputs.
module btn_conditioner_channel
    import btn_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw_i,
    input  logic repeat_en_i,
    output logic btn_level_o,
    output logic btn_press_o,
    output logic btn_release_o
);

    localparam int DCNT_W = cnt_width(DEBOUNCE_CYC);
    localparam int RCNT_W = cnt_width(max_int(REPEAT_DELAY, REPEAT_RATE));

    localparam logic [DCNT_W-1:0] DCNT_LAST  = DCNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [RCNT_W-1:0] DELAY_LAST = RCNT_W'(REPEAT_DELAY - 1);
    localparam logic [RCNT_W-1:0] RATE_LAST  = RCNT_W'(REPEAT_RATE - 1);

    logic [1:0]        sync_q;
    logic              level_q, level_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    rep_state_e        state_q;
    logic [RCNT_W-1:0] rcnt_q;
    logic [RCNT_W-1:0] rcnt_last;
    logic              press_q, release_q;
    logic              s, rise, fall;

    assign s = sync_q[1];

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        level_d = level_q;
        dcnt_d  = '0;
        if (s != level_q) begin
            if (dcnt_q == DCNT_LAST) begin
                level_d = ~level_q;
            end else begin
                dcnt_d = dcnt_q + DCNT_W'(1);
            end
        end
    end

    assign rise      = ~level_q &  level_d;
    assign fall      =  level_q & ~level_d;
    assign rcnt_last = (state_q == ST_DELAY) ? DELAY_LAST : RATE_LAST;

    // NOTE: state is written with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= '0;
            level_q   <= 1'b0;
            dcnt_q    <= '0;
            state_q   <= ST_IDLE;
            rcnt_q    <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], btn_raw_i};
            level_q   <= level_d;
            dcnt_q    <= dcnt_d;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            if (rise) begin
                state_q <= ST_DELAY;
                rcnt_q  <= '0;
                press_q <= 1'b1;
            end else if (fall) begin
                // A repeat expiring on the release edge is dropped here.
                state_q   <= ST_IDLE;
                rcnt_q    <= '0;
                release_q <= 1'b1;
            end else begin
                case (state_q)
                    ST_DELAY, ST_REPEAT: begin
                        if (!repeat_en_i) begin
                            rcnt_q <= '0;
                        end else if (rcnt_q == rcnt_last) begin
                            state_q <= ST_REPEAT;
                            rcnt_q  <= '0;
                            press_q <= 1'b1;
                        end else begin
                            rcnt_q <= rcnt_q + RCNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        rcnt_q  <= '0;
                    end
                endcase
            end
        end
    end

    assign btn_level_o   = level_q;
    assign btn_press_o   = press_q;
    assign btn_release_o = release_q;

endmodule

// File: rtl/btn_conditioner.sv
// Push-button conditioner: N_BTN independent channels turning raw pad levels
// into debounced levels and one-cycle press/repeat/release pulses.
module btn_conditioner
    import btn_conditioner_pkg::*;
#(
    parameter int N_BTN        = DEF_N_BTN,
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [N_BTN-1:0] repeat_en,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_conditioner_channel #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE)
        ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .btn_raw_i     (btn_raw[i]),
            .repeat_en_i   (repeat_en[i]),
            .btn_level_o   (btn_level[i]),
            .btn_press_o   (btn_press[i]),
            .btn_release_o (btn_release[i])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner: a sample-window reference model is
// compared every cycle, and directed scenarios pin pulse timing to literal offsets.
module tb_btn_conditioner;

    localparam int N    = 3;
    localparam int DEB  = 4;
    localparam int RD   = 10;
    localparam int RATE = 3;

    logic         clk;
    logic         rst;
    logic [N-1:0] btn_raw;
    logic [N-1:0] repeat_en;
    logic [N-1:0] btn_level, btn_press, btn_release;

    btn_conditioner #(
        .N_BTN        (N),
        .DEBOUNCE_CYC (DEB),
        .REPEAT_DELAY (RD),
        .REPEAT_RATE  (RATE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .repeat_en   (repeat_en),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: level flips once the last DEB synchronized samples all
    // disagree with it; repeats fire after a run of enabled cycles of the right length.
    logic [N-1:0] exp_level, exp_press, exp_release;
    bit           dl1 [N];
    bit           dl2 [N];
    bit           hist[N][$];
    int           run_m[N];
    int           nrep [N];
    int           press_log  [N][$];
    int           release_log[N][$];

    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < N; i++) begin
            bit s;
            bit all_diff;
            if (rst) begin
                dl1[i] = 1'b0;
                dl2[i] = 1'b0;
                hist[i].delete();
                run_m[i] = 0;
                nrep[i]  = 0;
                exp_level[i]   = 1'b0;
                exp_press[i]   = 1'b0;
                exp_release[i] = 1'b0;
            end else begin
                s      = dl2[i];
                dl2[i] = dl1[i];
                dl1[i] = btn_raw[i];
                hist[i].push_back(s);
                if (hist[i].size() > DEB) void'(hist[i].pop_front());
                all_diff = (hist[i].size() == DEB);
                foreach (hist[i][j]) if (hist[i][j] == exp_level[i]) all_diff = 1'b0;
                exp_press[i]   = 1'b0;
                exp_release[i] = 1'b0;
                if (all_diff) begin
                    exp_level[i] = ~exp_level[i];
                    if (exp_level[i]) begin
                        exp_press[i] = 1'b1;
                        run_m[i] = 0;
                        nrep[i]  = 0;
                    end else begin
                        exp_release[i] = 1'b1;
                    end
                end else if (exp_level[i]) begin
                    if (repeat_en[i]) begin
                        run_m[i]++;
                        if (run_m[i] == ((nrep[i] == 0) ? RD : RATE)) begin
                            exp_press[i] = 1'b1;
                            nrep[i]++;
                            run_m[i] = 0;
                        end
                    end else begin
                        run_m[i] = 0;
                    end
                end
                if (exp_press[i])   press_log[i].push_back(cyc);
                if (exp_release[i]) release_log[i].push_back(cyc);
            end
        end
        #1;
        check($sformatf("cycle %0d level/press/release", cyc),
              32'({btn_level, btn_press, btn_release}),
              32'({exp_level, exp_press, exp_release}));
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_logs();
        for (int i = 0; i < N; i++) begin
            press_log[i].delete();
            release_log[i].delete();
        end
    endtask

    task automatic check_offsets(input string name, input int ch, input int base,
                                 input int exp_off[$]);
        check({name, " press count"}, press_log[ch].size(), exp_off.size());
        foreach (exp_off[j]) begin
            if (j < press_log[ch].size())
                check($sformatf("%s press #%0d offset", name, j), press_log[ch][j] - base, exp_off[j]);
        end
    endtask

    task automatic check_release(input string name, input int ch, input int base, input int exp_off);
        check({name, " release count"}, release_log[ch].size(), 1);
        if (release_log[ch].size() > 0)
            check({name, " release offset"}, release_log[ch][0] - base, exp_off);
    endtask

    int k, kl, r;
    int exp_q[$];
    int bounce[$];
    int slow;

    initial begin
        rst       = 1'b1;
        btn_raw   = '0;
        repeat_en = '0;
        tick(3);
        check("reset btn_level",   32'(btn_level),   0);
        check("reset btn_press",   32'(btn_press),   0);
        check("reset btn_release", 32'(btn_release), 0);
        rst = 1'b0;
        tick(4);

        // Clean press on ch0, no repeat: latency 5 each way.
        clear_logs();
        k = cyc + 1;
        btn_raw[0] = 1'b1;
        tick(8);
        btn_raw[0] = 1'b0;
        kl = cyc + 1;
        tick(12);
        exp_q = {0};
        check_offsets("clean ch0", 0, k + 5, exp_q);
        check_release("clean ch0", 0, kl, 5);
        check("clean ch0 no ch1 activity", press_log[1].size(), 0);

        // Bounce on ch1 shorter than the debounce window.
        clear_logs();
        bounce = {1, 0, 1, 1, 0};
        foreach (bounce[j]) begin
            btn_raw[1] = bounce[j][0];
            tick(1);
        end
        btn_raw[1] = 1'b0;
        tick(15);
        check("bounce ch1 press count",   press_log[1].size(),   0);
        check("bounce ch1 release count", release_log[1].size(), 0);

        // Held ch2 with repeat; release lands on a repeat expiry, which is suppressed.
        clear_logs();
        repeat_en[2] = 1'b1;
        k = cyc + 1;
        btn_raw[2] = 1'b1;
        tick(31);
        btn_raw[2] = 1'b0;
        tick(12);
        repeat_en[2] = 1'b0;
        exp_q = {0, 10, 13, 16, 19, 22, 25, 28};
        check_offsets("repeat ch2", 2, k + 5, exp_q);
        check_release("repeat ch2", 2, k + 5, 31);

        // Repeat disabled from offset 12 to 20 on ch0.
        clear_logs();
        repeat_en[0] = 1'b1;
        k = cyc + 1;
        btn_raw[0] = 1'b1;
        tick(17);
        repeat_en[0] = 1'b0;
        tick(9);
        repeat_en[0] = 1'b1;
        tick(4);
        btn_raw[0] = 1'b0;
        tick(12);
        repeat_en[0] = 1'b0;
        exp_q = {0, 10, 23, 26, 29};
        check_offsets("gated ch0", 0, k + 5, exp_q);
        check_release("gated ch0", 0, k + 5, 30);

        // Reset pulse during a hold on ch1.
        repeat_en[1] = 1'b1;
        btn_raw[1]   = 1'b1;
        tick(12);
        rst = 1'b1;
        clear_logs();
        r = cyc + 1;
        tick(1);
        check("mid-hold reset btn_level",   32'(btn_level),   0);
        check("mid-hold reset btn_press",   32'(btn_press),   0);
        check("mid-hold reset btn_release", 32'(btn_release), 0);
        rst = 1'b0;
        tick(10);
        exp_q = {0};
        check_offsets("post-reset ch1", 1, r + 6, exp_q);
        check("post-reset ch1 no release", release_log[1].size(), 0);
        btn_raw[1]   = 1'b0;
        repeat_en[1] = 1'b0;
        tick(12);

        // Simultaneous press on all channels.
        clear_logs();
        repeat_en = '1;
        k = cyc + 1;
        btn_raw = '1;
        tick(15);
        btn_raw = '0;
        tick(12);
        repeat_en = '0;
        exp_q = {0, 10, 13};
        for (int i = 0; i < N; i++) begin
            check_offsets($sformatf("all ch%0d", i), i, k + 5, exp_q);
            check_release($sformatf("all ch%0d", i), i, k + 5, 15);
        end

        // Randomized traffic with alternating fast and slow toggle segments.
        for (int seg = 0; seg < 6; seg++) begin
            slow = seg % 2;
            repeat (500) begin
                for (int i = 0; i < N; i++) begin
                    if ($urandom_range(slow ? 39 : 7) == 0) btn_raw[i] = ~btn_raw[i];
                    if ($urandom_range(15) == 0) repeat_en[i] = ~repeat_en[i];
                end
                rst = ($urandom_range(499) == 0);
                tick(1);
            end
        end
        rst = 1'b0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
